// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b datapath types used by the MEM-stage access unit
// Purpose: bus word type, byte-enable type, MEM-stage FSM state enum and address helpers.
// Ports: none (package).
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_byte_en;

    localparam lc3b_byte_en BE_WORD = 2'b11;
    localparam lc3b_byte_en BE_LO   = 2'b01;
    localparam lc3b_byte_en BE_HI   = 2'b10;
    localparam lc3b_byte_en BE_NONE = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PTR_RD = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } lc3b_mem_state;

    // Word accesses always go to the even byte of the pair.
    function automatic lc3b_word word_align(input lc3b_word a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_stage_access_unit_byte_lane_mux.sv
// rtl/mem_stage_access_unit_byte_lane_mux.sv - byte lane steering and enable generation
// Purpose: maps a target address plus word/byte flag onto memory address, lane
//          enables, replicated store data and zero-extended load data.
// Ports:
//   addr_i       target byte address
//   byte_op_i    1 = byte access, 0 = word access
//   store_data_i store source value
//   rdata_i      raw memory read data
//   addr_o       memory address (word-aligned for word accesses)
//   be_o         lane enables, [1] = high byte
//   wdata_o      memory write data (low byte replicated on byte stores)
//   load_o       load result (byte loads zero-extended; sign extension happens in WB)
module byte_lane_mux
    import lc3b_types::*;
(
    input  logic [15:0] addr_i,
    input  logic        byte_op_i,
    input  logic [15:0] store_data_i,
    input  logic [15:0] rdata_i,
    output logic [15:0] addr_o,
    output logic [1:0]  be_o,
    output logic [15:0] wdata_o,
    output logic [15:0] load_o
);

    always_comb begin
        addr_o  = word_align(addr_i);
        be_o    = BE_WORD;
        wdata_o = store_data_i;
        load_o  = rdata_i;
        if (byte_op_i) begin
            addr_o  = addr_i;
            be_o    = addr_i[0] ? BE_HI : BE_LO;
            // Replicate so the byte lands on whichever lane is enabled.
            wdata_o = {store_data_i[7:0], store_data_i[7:0]};
            load_o  = {8'h00, (addr_i[0] ? rdata_i[15:8] : rdata_i[7:0])};
        end
    end

endmodule

// File: rtl/mem_stage_access_unit.sv
// rtl/mem_stage_access_unit.sv - MEM-stage data-port controller for the pipelined LC-3b
// Purpose: runs the data-memory request/response handshake for loads/stores in
//          EX/MEM, sequences LDI/STI as pointer read + access, steers byte lanes,
//          and stalls the upstream pipeline until the access completes.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mem_read_ex_mem/mem_write_ex_mem load/store request from EX/MEM
//   indirect, byte_op               LDI/STI and LDB/STB qualifiers
//   addr_in, store_data             effective address and store value
//   dmem_*                          data-memory request/response port
//   load_data                       last completed load result (held)
//   stall                           freeze IF/ID, ID/EX, EX/MEM, MEM/WB
//   timeout_err                     sticky wait-limit violation flag
module mem_stage_access_unit
    import lc3b_types::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_ex_mem,
    input  logic        mem_write_ex_mem,
    input  logic        indirect,
    input  logic        byte_op,
    input  logic [15:0] addr_in,
    input  logic [15:0] store_data,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [15:0] load_data,
    output logic        stall,
    output logic        timeout_err
);

    lc3b_mem_state state_q, state_d;
    lc3b_word      ptr_q, ptr_d;
    lc3b_word      load_data_q, load_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    logic     req;
    logic     is_write;
    logic     last_wait;
    logic     stall_c;
    lc3b_word tgt;
    lc3b_word lane_addr;
    lc3b_byte_en lane_be;
    lc3b_word lane_wdata;
    lc3b_word lane_load;

    assign req       = mem_read_ex_mem | mem_write_ex_mem;
    // Store wins when both strobes are set.
    assign is_write  = mem_write_ex_mem;
    assign tgt       = indirect ? ptr_q : addr_in;
    // A cycle without resp at this count would be the WAIT_LIMIT-th miss.
    assign last_wait = (cnt_q == CNT_W'(WAIT_LIMIT - 1));

    byte_lane_mux u_lane (
        .addr_i       (tgt),
        .byte_op_i    (byte_op),
        .store_data_i (store_data),
        .rdata_i      (dmem_rdata),
        .addr_o       (lane_addr),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .load_o       (lane_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            load_data_q <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            load_data_q <= load_data_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        load_data_d      = load_data_q;
        cnt_d            = cnt_q;
        timeout_d        = timeout_q;
        stall_c          = 1'b0;
        dmem_address     = '0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_byte_enable = BE_NONE;
        dmem_wdata       = lane_wdata;

        unique case (state_q)
            IDLE: begin
                stall_c = req;
                cnt_d   = '0;
                if (req) begin
                    state_d = indirect ? PTR_RD : ACCESS;
                end
            end
            PTR_RD: begin
                stall_c          = 1'b1;
                dmem_read        = 1'b1;
                dmem_address     = word_align(addr_in);
                dmem_byte_enable = BE_WORD;
                if (dmem_resp) begin
                    ptr_d   = dmem_rdata;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end else if (last_wait) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACCESS: begin
                stall_c          = 1'b1;
                dmem_address     = lane_addr;
                dmem_byte_enable = lane_be;
                dmem_write       = is_write;
                dmem_read        = ~is_write & mem_read_ex_mem;
                if (dmem_resp) begin
                    if (!is_write) begin
                        load_data_d = lane_load;
                    end
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (last_wait) begin
                    // Abandoned load leaves load_data untouched.
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // One free cycle lets the pipeline advance past this instruction.
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall is released as soon as reset is asserted, even with a request pending.
    assign stall       = stall_c & rst_n;
    assign load_data   = load_data_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// tb/tb_mem_stage_access_unit.sv - self-checking bench for mem_stage_access_unit
module tb_mem_stage_access_unit;

    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_ex_mem, mem_write_ex_mem, indirect, byte_op;
    logic [15:0] addr_in, store_data;
    logic [15:0] dmem_address, dmem_wdata, dmem_rdata, load_data;
    logic        dmem_read, dmem_write, dmem_resp, stall, timeout_err;
    logic [1:0]  dmem_byte_enable;

    always #5 clk = ~clk;

    mem_stage_access_unit #(.WAIT_LIMIT(WL), .CNT_W(3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read_ex_mem  (mem_read_ex_mem),
        .mem_write_ex_mem (mem_write_ex_mem),
        .indirect         (indirect),
        .byte_op          (byte_op),
        .addr_in          (addr_in),
        .store_data       (store_data),
        .dmem_address     (dmem_address),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .load_data        (load_data),
        .stall            (stall),
        .timeout_err      (timeout_err)
    );

    // One expected bus cycle, plus the response the bench drives in that cycle.
    typedef struct packed {
        logic        stall;
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] ld;
        logic        to;
        logic        resp;
        logic [15:0] rdata;
    } cyc_t;

    cyc_t        plan[$];
    cyc_t        cur;
    bit          cur_valid = 0;
    int          checks = 0;
    int          errors = 0;
    int          stall_cnt;
    logic [15:0] last_addr, last_wdata;
    logic [1:0]  last_be;
    logic [15:0] m_ld;
    bit          m_to;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: checks every cycle of a planned timeline.
    always @(negedge clk) begin
        if (cur_valid) begin
            chk("stall", 16'(stall), 16'(cur.stall));
            chk("dmem_read", 16'(dmem_read), 16'(cur.rd));
            chk("dmem_write", 16'(dmem_write), 16'(cur.wr));
            chk("load_data", load_data, cur.ld);
            chk("timeout_err", 16'(timeout_err), 16'(cur.to));
            chk("byte_enable", 16'(dmem_byte_enable), 16'(cur.be));
            if (cur.rd || cur.wr) chk("dmem_address", dmem_address, cur.addr);
            if (cur.wr) chk("dmem_wdata", dmem_wdata, cur.wdata);
            if (stall) stall_cnt++;
            if (dmem_read || dmem_write) begin
                last_addr  = dmem_address;
                last_be    = dmem_byte_enable;
                last_wdata = dmem_wdata;
            end
        end
    end

    function automatic cyc_t quiet_cycle();
        cyc_t e;
        e       = '0;
        e.ld    = m_ld;
        e.to    = m_to;
        e.rdata = 16'($urandom);
        return e;
    endfunction

    // Builds the whole timeline of one request from the behavioural rules:
    // one request cycle, pointer-read cycles (if indirect), access cycles,
    // one release cycle. A latency above WL means memory never answers.
    task automatic build_txn(input bit r, input bit w, input bit ind, input bit bop,
                             input logic [15:0] a, input logic [15:0] sd,
                             input int lp, input int la,
                             input logic [15:0] rp, input logic [15:0] ra);
        cyc_t e;
        int n;
        bit aborted;
        logic [15:0] tgt, ea, wd;
        logic [1:0] be;
        aborted = 0;
        tgt = a;
        e = quiet_cycle();
        e.stall = 1;
        plan.push_back(e);
        if (ind) begin
            n = (lp <= WL) ? lp : WL;
            for (int i = 0; i < n; i++) begin
                e = quiet_cycle();
                e.stall = 1; e.rd = 1; e.be = 2'b11; e.addr = a & 16'hFFFE;
                if (i == n - 1 && lp <= WL) begin e.resp = 1; e.rdata = rp; end
                plan.push_back(e);
            end
            if (lp <= WL) tgt = rp;
            else begin m_to = 1; aborted = 1; end
        end
        if (!aborted) begin
            if (bop) begin
                ea = tgt; be = tgt[0] ? 2'b10 : 2'b01; wd = {sd[7:0], sd[7:0]};
            end else begin
                ea = tgt & 16'hFFFE; be = 2'b11; wd = sd;
            end
            n = (la <= WL) ? la : WL;
            for (int i = 0; i < n; i++) begin
                e = quiet_cycle();
                e.stall = 1; e.rd = !w; e.wr = w; e.be = be; e.addr = ea; e.wdata = wd;
                if (i == n - 1 && la <= WL) begin e.resp = 1; e.rdata = ra; end
                plan.push_back(e);
            end
            if (la > WL) m_to = 1;
            else if (!w) m_ld = bop ? ((ra >> (8 * int'(tgt[0]))) & 16'h00FF) : ra;
        end
        plan.push_back(quiet_cycle());
    endtask

    task automatic play();
        stall_cnt = 0;
        while (plan.size() > 0) begin
            cur        = plan.pop_front();
            cur_valid  = 1;
            dmem_resp  = cur.resp;
            dmem_rdata = cur.rdata;
            @(posedge clk); #1;
        end
        cur_valid = 0;
        dmem_resp = 0;
    endtask

    task automatic run_txn(input bit r, input bit w, input bit ind, input bit bop,
                           input logic [15:0] a, input logic [15:0] sd,
                           input int lp, input int la,
                           input logic [15:0] rp, input logic [15:0] ra);
        mem_read_ex_mem = r; mem_write_ex_mem = w; indirect = ind; byte_op = bop;
        addr_in = a; store_data = sd;
        build_txn(r, w, ind, bop, a, sd, lp, la, rp, ra);
        play();
        mem_read_ex_mem = 0; mem_write_ex_mem = 0; indirect = 0; byte_op = 0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            cur        = quiet_cycle();
            cur.resp   = 1'($urandom);
            cur_valid  = 1;
            dmem_resp  = cur.resp;
            dmem_rdata = cur.rdata;
            @(posedge clk); #1;
        end
        cur_valid = 0;
        dmem_resp = 0;
    endtask

    task automatic random_txns(input int count, input bit allow_to);
        int k, lp, la;
        bit r, w;
        for (int t = 0; t < count; t++) begin
            k = $urandom_range(0, 2);
            r = (k != 1);
            w = (k != 0);
            lp = $urandom_range(1, WL);
            la = $urandom_range(1, WL);
            if (allow_to && ($urandom_range(0, 7) == 0)) la = WL + 1;
            if (allow_to && ($urandom_range(0, 15) == 0)) lp = WL + 2;
            run_txn(r, w, ($urandom_range(0, 3) == 0), 1'($urandom), 16'($urandom),
                    16'($urandom), lp, la, 16'($urandom), 16'($urandom));
            idle_gap($urandom_range(0, 2));
        end
    endtask

    initial begin
        rst_n = 0;
        mem_read_ex_mem = 0; mem_write_ex_mem = 0; indirect = 0; byte_op = 0;
        addr_in = 0; store_data = 0; dmem_rdata = 0; dmem_resp = 0;
        m_ld = 0; m_to = 0;
        #12;
        chk("reset dmem_read", 16'(dmem_read), 16'h0);
        chk("reset dmem_write", 16'(dmem_write), 16'h0);
        chk("reset byte_enable", 16'(dmem_byte_enable), 16'h0);
        chk("reset load_data", load_data, 16'h0);
        chk("reset timeout_err", 16'(timeout_err), 16'h0);
        chk("reset stall", 16'(stall), 16'h0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // Word load, resp in 3rd access cycle.
        run_txn(1, 0, 0, 0, 16'h1235, 16'h0, 1, 3, 16'h0, 16'hBEEF);
        chk("wl stall cycles", 16'(stall_cnt), 16'd4);
        chk("wl address", last_addr, 16'h1234);
        chk("wl be", 16'(last_be), 16'h3);
        chk("wl load_data", load_data, 16'hBEEF);

        // Byte store, high lane, same-cycle resp.
        run_txn(0, 1, 0, 1, 16'h2001, 16'h00A5, 1, 1, 16'h0, 16'h0);
        chk("sb stall cycles", 16'(stall_cnt), 16'd2);
        chk("sb address", last_addr, 16'h2001);
        chk("sb be", 16'(last_be), 16'h2);
        chk("sb wdata", last_wdata, 16'hA5A5);
        chk("sb load_data kept", load_data, 16'hBEEF);

        // LDB high lane.
        run_txn(1, 0, 0, 1, 16'h3003, 16'h0, 1, 1, 16'h0, 16'h8C11);
        chk("ldb load_data", load_data, 16'h008C);

        // STI: pointer read then word store.
        run_txn(0, 1, 1, 0, 16'h4000, 16'h1234, 1, 1, 16'h5006, 16'h0);
        chk("sti stall cycles", 16'(stall_cnt), 16'd3);
        chk("sti address", last_addr, 16'h5006);
        chk("sti be", 16'(last_be), 16'h3);
        chk("sti wdata", last_wdata, 16'h1234);

        random_txns(200, 0);

        // Timeout: memory never answers.
        chk("pre-timeout flag", 16'(timeout_err), 16'h0);
        run_txn(1, 0, 0, 0, 16'h6000, 16'h0, 1, WL + 3, 16'h0, 16'h0);
        chk("timeout stall cycles", 16'(stall_cnt), 16'(1 + WL));
        chk("timeout flag", 16'(timeout_err), 16'h1);
        run_txn(1, 0, 0, 0, 16'h6002, 16'h0, 1, 1, 16'h0, 16'h7777);
        chk("timeout sticky", 16'(timeout_err), 16'h1);
        chk("post-timeout load", load_data, 16'h7777);

        random_txns(60, 1);

        // Reset in the middle of an access.
        mem_read_ex_mem = 1; addr_in = 16'h0ABC;
        @(posedge clk); #1;
        chk("pre-reset read strobe", 16'(dmem_read), 16'h1);
        #2;
        rst_n = 0;
        #1;
        chk("midreset dmem_read", 16'(dmem_read), 16'h0);
        chk("midreset stall", 16'(stall), 16'h0);
        chk("midreset byte_enable", 16'(dmem_byte_enable), 16'h0);
        chk("midreset load_data", load_data, 16'h0);
        chk("midreset timeout_err", 16'(timeout_err), 16'h0);
        mem_read_ex_mem = 0;
        @(posedge clk); #1;
        rst_n = 1;
        m_ld = 0; m_to = 0;
        @(posedge clk); #1;
        random_txns(20, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- MEM-stage data-port controller for the pipelined LC-3b datapath.
- Consumes the EX/MEM pipeline register outputs (mem_read/mem_write strobes, address, store data, byte/indirect flags) and runs the data-memory request/response handshake.
- Sequences LDI/STI as two accesses, handles byte lanes for LDB/STB, and drives a stall that freezes the IF/ID, ID/EX, EX/MEM and MEM/WB registers until the access completes.

Parameters:
WAIT_LIMIT, 255, max cycles to wait for mem_resp in one access before flagging a timeout.
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mem_read_ex_mem  input  1  load requested by instruction in EX/MEM
mem_write_ex_mem  input  1  store requested by instruction in EX/MEM
indirect  input  1  LDI/STI: first read the pointer at addr_in, then access the pointer target
byte_op  input  1  LDB/STB byte access
addr_in  input  16  effective address (EX/MEM adder output)
store_data  input  16  store source register value
dmem_address  output  16  data-memory address
dmem_read  output  1  data-memory read strobe
dmem_write  output  1  data-memory write strobe
dmem_byte_enable  output  2  lane enables, [1]=high byte
dmem_wdata  output  16  data-memory write data
dmem_rdata  input  16  data-memory read data
dmem_resp  input  1  access complete this cycle
load_data  output  16  load result to MEM/WB, held until the next load completes
stall  output  1  freeze all upstream pipeline registers
timeout_err  output  1  sticky timeout flag

Behaviour:
- States: IDLE, PTR_RD, ACCESS, DONE.
- Reset (async, rst_n=0):
  - State goes to IDLE; ptr_q, load_data, wait counter and timeout_err are all 0.
  - dmem_read, dmem_write and dmem_byte_enable are 0.
  - Reset mid-access abandons the transaction with no retry.
- IDLE:
  - stall = mem_read_ex_mem | mem_write_ex_mem, combinational.
  - If a request is present: go to PTR_RD if indirect, otherwise go to ACCESS.
  - No dmem strobes are driven in IDLE.
- PTR_RD:
  - Drives dmem_read=1, dmem_address={addr_in[15:1],1'b0}, byte_enable=2'b11; stall=1.
  - On dmem_resp: ptr_q<=dmem_rdata, then go to ACCESS.
- ACCESS:
  - Target address tgt = indirect ? ptr_q : addr_in. stall=1.
  - Write has priority if both strobes are set; in that case read is ignored.
  - Word access: address={tgt[15:1],0}, byte_enable=11, wdata=store_data.
  - Byte access: address=tgt, byte_enable = tgt[0] ? 10 : 01, wdata={store_data[7:0],store_data[7:0]}.
  - Load on dmem_resp:
    - Word: load_data<=dmem_rdata.
    - Byte: load_data<={8'h00, selected byte}, where the selected byte is dmem_rdata[15:8] if tgt[0]=1, otherwise [7:0]. Sign extension is done in WB, not here.
  - On dmem_resp, go to DONE.
- DONE:
  - stall=0 and no strobes for exactly one cycle, so the pipeline advances.
  - Always returns to IDLE, which prevents the same instruction from being re-issued.
- Strobe timing:
  - Strobes are asserted from the cycle the state is entered until the cycle dmem_resp is sampled high, inclusive.
  - Address, data and enables are stable throughout.
- Latency:
  - Plain access: stall is high for 1 (IDLE) + N cycles, where N is ACCESS cycles up to and including the resp cycle.
  - Indirect access: adds the PTR_RD cycles.
  - Minimum stall with same-cycle response is 2 cycles plain and 3 cycles indirect.
- Wait counter:
  - Cleared on each state entry; increments each PTR_RD/ACCESS cycle without resp.
  - When it reaches WAIT_LIMIT: timeout_err<=1 (sticky until reset), the access is abandoned, and the FSM goes to DONE.
  - On a timed-out load, load_data is unchanged.
- dmem_resp seen in IDLE or DONE is ignored.

Decomposition:
- Shared lc3b_types gains:
  - lc3b_mem_state enum (IDLE, PTR_RD, ACCESS, DONE).
  - lc3b_byte_en (2-bit) typedef.
  - Constant BE_WORD=2'b11.
- Existing lc3b_word is used for all 16-bit buses.
- One natural sub-module, byte_lane_mux: combinational lane steering for loads and stores plus enable generation, reusable by a future dcache.

Test Plan:
- Word load: addr_in=0x1235, read=1, resp in the 3rd ACCESS cycle with rdata=0xBEEF -> dmem_address=0x1234, be=11; stall high 4 cycles then low 1; load_data=0xBEEF.
- Byte store: addr_in=0x2001, store_data=0x00A5, write=1, same-cycle resp -> address=0x2001, be=10, wdata=0xA5A5; stall exactly 2 cycles.
- LDB high lane: addr_in=0x3003, byte_op=1, rdata=0x8C11 -> load_data=0x008C.
- STI: addr_in=0x4000; pointer rdata=0x5006; store_data=0x1234 -> read 0x4000, then write 0x5006, be=11; stall 3 cycles minimum.
- Reset mid-access: rst_n low during ACCESS -> strobes and stall drop immediately, state IDLE, load_data=0.
- Timeout: no resp, WAIT_LIMIT=4 -> timeout_err=1 after 4 ACCESS cycles, one DONE cycle, flag stays set.
